// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types, frame field helpers and parity for spi_ram_ctrl.
// RAM_PARITY_EN widens the RAM word by one even-parity bit.
package spi_ram_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int INST_W = 1 + ADDR_W + DATA_W;
`ifdef RAM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ = 1'b0;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD} ctrl_state_e;
  function automatic logic frame_op(input logic [INST_W-1:0] f);
    return f[INST_W-1];
  endfunction
  function automatic logic [ADDR_W-1:0] frame_addr(input logic [INST_W-1:0] f);
    return f[INST_W-2:DATA_W];
  endfunction
  function automatic logic [DATA_W-1:0] frame_data(input logic [INST_W-1:0] f);
    return f[DATA_W-1:0];
  endfunction
  function automatic logic parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/spi_ram_rd_pipe.sv
// spi_ram_rd_pipe: RAM_LATENCY-deep valid shift register flagging the read-data capture cycle.
module spi_ram_rd_pipe #(
  parameter int LAT = 1
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic issue,
  output logic cap
);
  logic [LAT-1:0] sr;
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else sr <= LAT'({sr, issue});
  end
  assign cap = sr[LAT-1];
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: turns SPI slave frames into single-port RAM writes/reads and returns read data.
// Define RAM_PARITY_EN to store and check an even-parity bit per RAM word.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int DATA_SIZE = DATA_W,
  parameter int ADDR_SIZE = ADDR_W,
  parameter int INST_SIZE = INST_W,
  parameter int RAM_LATENCY = 1
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic [INST_SIZE-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [RAM_W-1:0]     ram_wdata,
  input  logic [RAM_W-1:0]     ram_rdata,
  output logic                 busy,
  output logic                 frame_abort,
  output logic                 par_err
);
  ctrl_state_e state, next;
  logic rx_valid_q, aborted, cap, accept, drop, mism;
  logic ram_en_d, ram_we_d, busy_d, tx_valid_d, abort_d, par_err_d, deliver;
  assign accept = state == IDLE && rx_valid && !rx_valid_q;
  assign drop = aborted || !rx_valid;
  assign deliver = state == RD_WAIT && cap && !drop;
`ifdef RAM_PARITY_EN
  assign mism = ram_rdata[DATA_SIZE] ^ parity(ram_rdata[DATA_SIZE-1:0]);
`else
  assign mism = 1'b0;
`endif
  spi_ram_rd_pipe #(.LAT(RAM_LATENCY)) u_rd_pipe (
    .sclk (sclk),
    .rst_n(rst_n),
    .issue(state == RD_ISSUE),
    .cap  (cap)
  );
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_valid_q  <= 1'b1;
      aborted     <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      busy        <= 1'b0;
      tx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      par_err     <= 1'b0;
      tx_data     <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      state       <= next;
      rx_valid_q  <= rx_valid;
      aborted     <= (state == RD_ISSUE || state == RD_WAIT) && (aborted || !rx_valid);
      ram_en      <= ram_en_d;
      ram_we      <= ram_we_d;
      busy        <= busy_d;
      tx_valid    <= tx_valid_d;
      frame_abort <= abort_d;
      par_err     <= par_err_d;
      if (deliver) tx_data <= ram_rdata[DATA_SIZE-1:0];
      if (accept) ram_addr <= frame_addr(rx_data);
`ifdef RAM_PARITY_EN
      if (accept && frame_op(rx_data) == OP_WRITE) ram_wdata <= {parity(frame_data(rx_data)), frame_data(rx_data)};
`else
      if (accept && frame_op(rx_data) == OP_WRITE) ram_wdata <= frame_data(rx_data);
`endif
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (accept) next = frame_op(rx_data) == OP_WRITE ? WR : RD_ISSUE;
      WR:       next = IDLE;
      RD_ISSUE: next = RD_WAIT;
      RD_WAIT:  if (cap) next = drop ? IDLE : RD_HOLD;
      RD_HOLD:  if (!rx_valid) next = IDLE;
      default:  next = IDLE;
    endcase
  end
  // outputs are computed from the next state so they line up with the registered state
  always_comb begin
    ram_en_d   = next == WR || next == RD_ISSUE;
    ram_we_d   = next == WR;
    busy_d     = next != IDLE;
    tx_valid_d = next == RD_HOLD;
    abort_d    = state == RD_WAIT && cap && drop;
    par_err_d  = deliver && mism;
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: table-driven and randomized frames checked against a frame-level timing/memory model.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;
  localparam int LAT = 3;
  logic sclk = 0, rst_n = 1;
  logic [15:0] rx_data = '0;
  logic rx_valid = 0;
  logic [7:0] tx_data;
  logic tx_valid, ram_en, ram_we, busy, frame_abort, par_err;
  logic [6:0] ram_addr;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;
  always #5 sclk = ~sclk;

  spi_ram_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(7), .INST_SIZE(16), .RAM_LATENCY(LAT)) dut (
    .sclk(sclk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .frame_abort(frame_abort), .par_err(par_err)
  );

  // RAM macro stand-in: data valid exactly LAT cycles after the enable cycle, garbage otherwise
  logic [RAM_W-1:0] mem [128] = '{default: '0};
  logic [RAM_W-1:0] rpipe [LAT];
  function automatic logic [RAM_W-1:0] rd_word(input logic [6:0] a);
    logic [RAM_W-1:0] w;
    w = mem[a];
`ifdef RAM_PARITY_EN
    if (a == 7'h05) w[8] = ~w[8];
`endif
    return w;
  endfunction
  always @(posedge sclk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    rpipe[0] <= (ram_en && !ram_we) ? rd_word(ram_addr) : RAM_W'($urandom);
    for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[LAT-1];

  int cyc = 0, en_cnt = 0, en_cyc = 0, tv_cnt = 0, tv_rise = 0, tv_fall = 0;
  int ab_cnt = 0, ab_cyc = 0, pe_cnt = 0, pe_cyc = 0, busy_cnt = 0;
  logic en_we = 0, tv_prev = 0;
  logic [6:0] en_addr = '0;
  logic [RAM_W-1:0] en_wd = '0;
  logic [7:0] tv_data = '0;
  always @(posedge sclk) cyc <= cyc + 1;
  always @(negedge sclk) begin
    if (ram_en) begin
      en_cnt++; en_cyc = cyc; en_we = ram_we; en_addr = ram_addr; en_wd = ram_wdata;
    end
    if (tx_valid && !tv_prev) begin
      tv_cnt++; tv_rise = cyc; tv_data = tx_data;
    end
    if (!tx_valid && tv_prev) tv_fall = cyc;
    if (frame_abort) begin ab_cnt++; ab_cyc = cyc; end
    if (par_err) begin pe_cnt++; pe_cyc = cyc; end
    if (busy) busy_cnt++;
    tv_prev = tx_valid;
  end

  int n_cmp = 0, n_err = 0;
  logic [7:0] model [128] = '{default: '0};
  logic [7:0] last_tx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one frame: rx_valid high for hi cycles, then idle long enough for the FSM to settle
  task automatic do_frame(input logic op, input logic [6:0] a, input logic [7:0] d, input int hi,
                          input bit exp_del, input logic [7:0] exp_d);
    int s, e0, t0, a0, p0, b0, exp_pe;
    @(negedge sclk);
    s = cyc; e0 = en_cnt; t0 = tv_cnt; a0 = ab_cnt; p0 = pe_cnt; b0 = busy_cnt;
    rx_data = {op, a, d};
    rx_valid = 1;
    repeat (hi) @(negedge sclk);
    rx_valid = 0;
    repeat (LAT + 4) @(negedge sclk);
    chk("en_count", en_cnt - e0, 1);
    chk("en_cycle", en_cyc - s, 1);
    chk("en_we", en_we, op);
    chk("en_addr", en_addr, a);
    exp_pe = 0;
`ifdef RAM_PARITY_EN
    exp_pe = (a == 7'h05) ? 1 : 0;
`endif
    if (op) begin
      chk("wr_data", en_wd[7:0], d);
`ifdef RAM_PARITY_EN
      chk("wr_par", en_wd[8], ^d);
`endif
      chk("wr_busy", busy_cnt - b0, 1);
      chk("wr_tv", tv_cnt - t0, 0);
      chk("wr_abort", ab_cnt - a0, 0);
      model[a] = d;
    end else if (exp_del) begin
      chk("rd_tv_cnt", tv_cnt - t0, 1);
      chk("rd_rise", tv_rise - s, LAT + 2);
      chk("rd_data", tv_data, exp_d);
      chk("rd_fall", tv_fall - s, hi + 1);
      chk("rd_busy", busy_cnt - b0, hi);
      chk("rd_abort", ab_cnt - a0, 0);
      chk("rd_par_cnt", pe_cnt - p0, exp_pe);
      if (exp_pe != 0) chk("rd_par_cyc", pe_cyc - s, LAT + 2);
      last_tx = exp_d;
    end else begin
      chk("ab_tv", tv_cnt - t0, 0);
      chk("ab_cnt", ab_cnt - a0, 1);
      chk("ab_cyc", ab_cyc - s, LAT + 2);
      chk("ab_busy", busy_cnt - b0, LAT + 1);
      chk("ab_par", pe_cnt - p0, 0);
    end
    chk("idle_busy", busy, 0);
    chk("idle_tv", tx_valid, 0);
    chk("tx_hold", tx_data, last_tx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_abort"}, frame_abort, 0);
    chk({tag, "_par"}, par_err, 0);
  endtask

  typedef struct {
    logic op; logic [6:0] a; logic [7:0] d; int hi; bit del; logic [7:0] xd;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int e0, t0, hi;
    logic op;
    logic [6:0] a;
    logic [7:0] d;
    tbl = '{
      '{1'b1, 7'h12, 8'hA5, 2,       1'b0, 8'h00},
      '{1'b0, 7'h12, 8'h00, LAT + 3, 1'b1, 8'hA5},
      '{1'b1, 7'h7F, 8'h3C, 1,       1'b0, 8'h00},
      '{1'b0, 7'h7F, 8'h00, LAT + 2, 1'b1, 8'h3C},
      '{1'b0, 7'h12, 8'h00, 1,       1'b0, 8'h00},
      '{1'b1, 7'h00, 8'hFF, 4,       1'b0, 8'h00},
      '{1'b0, 7'h00, 8'h00, LAT + 2, 1'b1, 8'hFF},
      '{1'b1, 7'h05, 8'h5A, 1,       1'b0, 8'h00},
      '{1'b0, 7'h05, 8'h00, LAT + 5, 1'b1, 8'h5A},
      '{1'b0, 7'h7F, 8'h00, LAT + 1, 1'b0, 8'h00}
    };
    // a frame already valid when reset releases must be ignored
    rx_data = {1'b1, 7'h33, 8'h77};
    rx_valid = 1;
    #1 rst_n = 0;
    #12 chk_zero("reset");
    @(negedge sclk);
    rst_n = 1;
    repeat (LAT + 4) @(negedge sclk);
    chk("held_frame_en", en_cnt, 0);
    chk("held_frame_busy", busy, 0);
    rx_valid = 0;
    repeat (2) @(negedge sclk);
    for (int i = 0; i < 10; i++)
      do_frame(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].hi, tbl[i].del, tbl[i].xd);
    // reset in RD_WAIT clears outputs at once; the still-high rx_valid is not re-accepted
    @(negedge sclk);
    rx_data = {1'b0, 7'h12, 8'h00};
    rx_valid = 1;
    repeat (3) @(negedge sclk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 0;
    #1 chk_zero("midreset");
    @(negedge sclk);
    rst_n = 1;
    e0 = en_cnt; t0 = tv_cnt;
    repeat (LAT + 4) @(negedge sclk);
    chk("post_reset_en", en_cnt - e0, 0);
    chk("post_reset_tv", tv_cnt - t0, 0);
    rx_valid = 0;
    last_tx = '0;
    repeat (2) @(negedge sclk);
    do_frame(1'b0, 7'h12, 8'h00, LAT + 2, 1'b1, model[7'h12]);
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'($urandom_range(0, 5));
      d = 8'($urandom);
      hi = $urandom_range(1, LAT + 4);
      do_frame(op, a, d, hi, !op && hi >= LAT + 2, model[a]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
